mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register; stable after FETCH.
REQ-005 mem_ready  input  1  memory handshake; 1 = the current access completes this cycle.
REQ-006 pc_write  output  1  unconditional PC load enable.
REQ-007 pc_write_cond  output  1  PC load enable qualified by ALU zero (branch).
REQ-008 i_or_d  output  1  memory address mux select; 0 = PC, 1 = ALUOut.
REQ-009 mem_read  output  1  memory read strobe.
REQ-010 mem_write  output  1  memory write strobe.
REQ-011 ir_write  output  1  instruction register load enable.
REQ-012 mem_to_reg  output  1  write-back mux select; 0 = ALUOut, 1 = MDR.
REQ-013 reg_dst  output  1  destination mux select; 0 = rt, 1 = rd.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 alu_src_a  output  1  ALU A mux select; 0 = PC, 1 = rs.
REQ-016 alu_src_b  output  2  4:1 ALU B mux select {s1,s0}; 00 rt, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-017 alu_op  output  2  00 add, 01 sub, 10 decode funct.
REQ-018 pc_source  output  2  4:1 PC mux select; 00 ALU result, 01 ALUOut, 10 jump target.
REQ-019 illegal_op  output  1  one-cycle pulse for unsupported opcode.
REQ-020 state_out  output  4  current state encoding, for debug.
REQ-021 retired  output  CNT_W  count of completed instructions.

Function
REQ-022 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 SHALL transition to FETCH.
REQ-023 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-024 DECODE: alu_src_b=11, alu_op=00; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with illegal_op=1 in that DECODE cycle only.
REQ-025 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; opcode 100011 -> MEMRD, otherwise -> MEMWR.
REQ-026 MEMRD: mem_read=1, i_or_d=1; waits while mem_ready=0, then -> MEMWB.
REQ-027 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-028 MEMWR: mem_write=1, i_or_d=1; waits while mem_ready=0, then -> FETCH.
REQ-029 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB; ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-031 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-032 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-033 Outputs not listed for a state SHALL be 0; mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-034 retired SHALL increment by 1 on every transition into FETCH from any state other than FETCH or DECODE; it SHALL wrap from 2^CNT_W-1 to 0; illegal opcodes SHALL NOT count.
REQ-035 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-036 While reset=1 at a rising edge, state SHALL become FETCH and retired SHALL become 0, overriding any in-progress transition, including mid-wait in MEMRD/MEMWR.
REQ-037 After reset, outputs SHALL equal the FETCH decode of REQ-023 and illegal_op SHALL be 0.

Structure
REQ-038 State encodings, opcode constants and alu_src_b/alu_op/pc_source codes SHALL live in a shared package mips_ctrl_pkg.
REQ-039 Output decode SHALL be a single sub-module mc_ctrl_decode (state -> control outputs, purely combinational); next-state logic and the counter stay in mc_control.

Verification
REQ-040 lw (100011), mem_ready=1 throughout -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired 0->1.
REQ-041 sw (101011), mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, i_or_d=1, then FETCH; retired +1.
REQ-042 beq (000100) -> states 0,1,8,0; pc_write_cond=1, pc_source=01, alu_op=01 in state 8 only.
REQ-043 opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
REQ-044 reset=1 while in MEMRD with mem_ready=0 -> state_out=0 and retired=0 the next cycle; CNT_W=2 after 4 retired instructions -> retired=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS control unit.
//               Holds the FSM state encoding, the supported opcodes, the
//               ALU/PC mux select codes and the bundled control-word struct.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // FSM states; encodings 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  // Supported opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU B operand select.
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath control signals for one cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // True for opcodes that DECODE knows how to dispatch.
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Purely combinational state -> control-word decode for the
//               multi-cycle control FSM.
// Ports       : state     - current FSM state
//               mem_ready - memory handshake (gates IR/PC load in FETCH)
//               opcode    - instruction opcode (flags illegal in DECODE)
//               ctrl      - bundled datapath control outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the fetch actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = ALUB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~is_supported(opcode);
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : Multi-cycle MIPS control unit. Moore FSM sequencing
//               lw/sw/R-type/beq/addi/j, plus a retired-instruction counter.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               opcode, mem_ready     - instruction opcode, memory handshake
//               pc_write ... pc_source - datapath control outputs
//               illegal_op            - pulse in DECODE for unsupported opcode
//               state_out             - current state (debug)
//               retired               - completed instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     next_state;
  logic       count_en;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (count_en) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_ADDI:      next_state = ST_ADDIEX;
          OP_J:         next_state = ST_JUMP;
          default:      next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: next_state = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  next_state = ST_FETCH;
      ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   next_state = ST_ALUWB;
      ST_ALUWB:  next_state = ST_FETCH;
      ST_BRANCH: next_state = ST_FETCH;
      ST_ADDIEX: next_state = ST_ADDIWB;
      ST_ADDIWB: next_state = ST_FETCH;
      ST_JUMP:   next_state = ST_FETCH;
      default:   next_state = ST_FETCH;
    endcase
  end

  // An instruction retires when it returns to FETCH from its last state.
  // FETCH->FETCH is a fetch wait and DECODE->FETCH is an illegal opcode,
  // so neither counts.
  assign count_en = (next_state == ST_FETCH) &&
                    (state != ST_FETCH) && (state != ST_DECODE);

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_out     = state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mc_control
// Description : Self-checking bench for mc_control. Two instances share the
//               stimulus: default CNT_W and CNT_W=2 (counter wrap). Each
//               scenario pushes the expected per-cycle state/retired trace to
//               a scoreboard and pops it as the DUT steps through the cycles.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;

  always #5 clk = ~clk;

  logic        pw_a, pwc_a, iod_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, ill_a;
  logic [1:0]  asb_a, aop_a, psrc_a;
  logic [3:0]  state_out;
  logic [31:0] retired;

  logic        pw_b, pwc_b, iod_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, ill_b;
  logic [1:0]  asb_b, aop_b, psrc_b;
  logic [3:0]  state_out_b;
  logic [1:0]  retired_b;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_a), .pc_write_cond(pwc_a), .i_or_d(iod_a), .mem_read(mrd_a),
    .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rdst_a),
    .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
    .pc_source(psrc_a), .illegal_op(ill_a), .state_out(state_out), .retired(retired)
  );

  mc_control #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_b), .pc_write_cond(pwc_b), .i_or_d(iod_b), .mem_read(mrd_b),
    .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rdst_b),
    .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
    .pc_source(psrc_b), .illegal_op(ill_b), .state_out(state_out_b), .retired(retired_b)
  );

  logic [16:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pw_a, pwc_a, iod_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a,
                   asb_a, aop_a, psrc_a, ill_a};
  assign ctrl_b = {pw_b, pwc_b, iod_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b,
                   asb_b, aop_b, psrc_b, ill_b};

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  st;
    logic        mr;
    logic [31:0] ret;
  } sb_item_t;

  sb_item_t    sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  prev_st;
  logic [31:0] exp_ret;

  // Reference control word from the state table, same bit order as ctrl_a.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic [5:0] op);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin
        asb = 2'b11;
        ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: begin rw = 1; end
      4'd11: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  // Queue one expected cycle; retired bumps on entry to FETCH from a
  // state other than FETCH or DECODE.
  task automatic push(input logic [5:0] op, input logic [3:0] st, input logic mr);
    if (st == 4'd0 && prev_st != 4'd0 && prev_st != 4'd1) exp_ret = exp_ret + 1;
    prev_st = st;
    sb.push_back('{op: op, st: st, mr: mr, ret: exp_ret});
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h3f;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    prev_st = 4'd0; exp_ret = 0;
    total++;
    if (state_out !== 4'd0 || retired !== 32'd0 || ctrl_a !== exp_ctrl(4'd0, 1'b1, 6'h3f) ||
        ill_a !== 1'b0 || retired_b !== 2'd0) begin
      bad++;
      $display("FAIL reset: state=%0d ret=%0d ctrl=%h, required state=0 ret=0 ctrl=%h",
               state_out, retired, ctrl_a, exp_ctrl(4'd0, 1'b1, 6'h3f));
    end
  endtask

  task automatic test_lw();
    sb_item_t it;
    push(6'b100011, 0, 1); push(6'b100011, 1, 1); push(6'b100011, 2, 1);
    push(6'b100011, 3, 1); push(6'b100011, 4, 1); push(6'b100011, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL lw: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    sb_item_t it;
    push(6'b101011, 0, 1); push(6'b101011, 1, 0); push(6'b101011, 2, 0);
    push(6'b101011, 5, 0); push(6'b101011, 5, 0); push(6'b101011, 5, 0);
    push(6'b101011, 5, 1); push(6'b101011, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL sw_wait: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    sb_item_t it;
    push(6'b000100, 0, 0); push(6'b000100, 0, 1); push(6'b000100, 1, 0);
    push(6'b000100, 8, 1); push(6'b000100, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL beq: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    sb_item_t it;
    push(6'b111111, 0, 1); push(6'b111111, 1, 1); push(6'b111111, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL illegal: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    sb_item_t it;
    // R-type with mem_ready toggling where it must be ignored
    push(6'b000000, 0, 1); push(6'b000000, 1, 0); push(6'b000000, 6, 1); push(6'b000000, 7, 0);
    // addi
    push(6'b001000, 0, 1); push(6'b001000, 1, 1); push(6'b001000, 9, 0); push(6'b001000, 10, 1);
    // j
    push(6'b000010, 0, 1); push(6'b000010, 1, 1); push(6'b000010, 11, 1);
    // lw with one read wait
    push(6'b100011, 0, 1); push(6'b100011, 1, 1); push(6'b100011, 2, 0);
    push(6'b100011, 3, 0); push(6'b100011, 3, 1); push(6'b100011, 4, 0); push(6'b100011, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL back_to_back: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    sb_item_t it;
    push(6'b100011, 0, 1); push(6'b100011, 1, 1); push(6'b100011, 2, 1); push(6'b100011, 3, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL reset_mid_wait: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
    // Still waiting in MEMRD; reset must abort the access.
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    prev_st = 4'd0; exp_ret = 0;
    total++;
    if (state_out !== 4'd0 || retired !== 32'd0 || retired_b !== 2'd0 ||
        ctrl_a !== exp_ctrl(4'd0, 1'b0, 6'b100011)) begin
      bad++;
      $display("FAIL reset_mid_wait_after: state=%0d ret=%0d ret2=%0d ctrl=%h, required state=0 ret=0 ctrl=%h",
               state_out, retired, retired_b, ctrl_a, exp_ctrl(4'd0, 1'b0, 6'b100011));
    end
  endtask

  task automatic test_wrap();
    sb_item_t it;
    for (int k = 0; k < 4; k++) begin
      push(6'b000010, 0, 1); push(6'b000010, 1, 1); push(6'b000010, 11, 0);
    end
    push(6'b000010, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front(); opcode = it.op; mem_ready = it.mr; #1; total++;
      if (state_out !== it.st || ctrl_a !== exp_ctrl(it.st, it.mr, it.op) || retired !== it.ret ||
          state_out_b !== it.st || ctrl_b !== exp_ctrl(it.st, it.mr, it.op) || retired_b !== it.ret[1:0]) begin
        bad++;
        $display("FAIL wrap: state=%0d ctrl=%h ret=%0d ret2=%0d, required state=%0d ctrl=%h ret=%0d",
                 state_out, ctrl_a, retired, retired_b, it.st, exp_ctrl(it.st, it.mr, it.op), it.ret);
      end
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 32'd4 || retired_b !== 2'd0) begin
      bad++;
      $display("FAIL wrap_final: ret=%0d ret2=%0d, required ret=4 ret2=0", retired, retired_b);
    end
  endtask

  initial begin
    prev_st = 4'd0;
    exp_ret = 0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
